periph_bus_master: RTL and testbench

- Initiator for the peripheral chip-select bus (addr / idata / odata / cs_ / rw_), the bus that timer-class responders sit on.
- Accepts single read/write requests from the CPU load/store path over a valid/ready handshake.
- Sequences the bus strobes: exactly one cs_-low cycle per transaction, so write-triggered commands (clear/start/stop) fire once.
- Returns read data or write completion on a one-cycle response pulse.

---
 rtl/periph_bus_master.sv | 108 ++++++++++
 tb/tb_periph_bus_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_master.sv
// Initiator for the peripheral chip-select bus: one request in, one cs_ strobe, one response out.
// Optional PBM_POSTED_WRITE_EN: writes respond in SETUP while the bus sequence finishes behind.
module periph_bus_master #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw_,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  cs_,
  output logic                  rw_
);

  localparam logic       RwRead   = 1'b1;
  localparam logic [3:0] HoldLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  cs_q, cs_d;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  accept;
  logic                  capture;

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign accept    = req_valid && req_ready;

  // Sample read data on the last edge before RESP.
  assign capture = rw_q && (((state_q == StHold) && (cnt_q == 4'd0)) ||
                            ((state_q == StStrobe) && (WAIT_CYCLES == 0)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StStrobe;
      StStrobe: begin
        if (WAIT_CYCLES == 0) begin
          state_d = StResp;
        end else begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // cs_ is registered from the next state so the strobe is a single clean low cycle.
  assign cs_d = (state_d != StStrobe);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      cs_q    <= 1'b1;
      rw_q    <= RwRead;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      if (accept) begin
        rw_q    <= req_rw_;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (capture) rdata_q <= bus_rdata;
    end
  end

`ifdef PBM_POSTED_WRITE_EN
  assign resp_valid = rw_q ? (state_q == StResp) : (state_q == StSetup);
`else
  assign resp_valid = (state_q == StResp);
`endif

  assign resp_rdata = rdata_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign cs_        = cs_q;
  assign rw_        = rw_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: three instances (WAIT_CYCLES 0, 1, 15), each on a small
// timer-like responder; expected timing and data come from a transaction-level model.
module tb_periph_bus_master;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NI = 3;

  function automatic int wc(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 15);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a      [NI];
  logic          req_valid  [NI];
  logic          req_ready  [NI];
  logic          req_rw_    [NI];
  logic [AW-1:0] req_addr   [NI];
  logic [DW-1:0] req_wdata  [NI];
  logic          resp_valid [NI];
  logic [DW-1:0] resp_rdata [NI];
  logic          busy       [NI];
  logic [AW-1:0] bus_addr   [NI];
  logic [DW-1:0] bus_wdata  [NI];
  logic [DW-1:0] bus_rdata  [NI];
  logic          cs_        [NI];
  logic          rw_        [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    periph_bus_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WAIT_CYCLES(wc(g))
    ) u_dut (
      .clk       (clk),
      .rst_      (rst_a[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_rw_   (req_rw_[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .busy      (busy[g]),
      .bus_addr  (bus_addr[g]),
      .bus_wdata (bus_wdata[g]),
      .bus_rdata (bus_rdata[g]),
      .cs_       (cs_[g]),
      .rw_       (rw_[g])
    );
  end

  // Responder: addr 0 = counter, addr 1 bit1 = counter enable, addrs 2..3 plain registers.
  logic          periph_clr;
  logic [DW-1:0] regs  [NI][4];
  logic [DW-1:0] timer [NI];
  int            wr_cnt[NI], cs_cnt[NI], resp_cnt[NI], dbl_cs[NI];
  logic          prev_cs[NI];
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (periph_clr) begin
        timer[i]  <= '0;
        wr_cnt[i] <= 0;
        for (int j = 0; j < 4; j++) regs[i][j] <= '0;
      end else begin
        if (cs_[i] === 1'b0 && rw_[i] === 1'b0) begin
          regs[i][bus_addr[i][1:0]] <= bus_wdata[i];
          wr_cnt[i] <= wr_cnt[i] + 1;
        end
        if (cs_[i] === 1'b0 && rw_[i] === 1'b0 && bus_addr[i][1:0] == 2'd0)
          timer[i] <= bus_wdata[i];
        else if (regs[i][1][1])
          timer[i] <= timer[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      bus_rdata[i] = '0;
      bus_rdata[i] = (bus_addr[i][1:0] == 2'd0) ? timer[i] : regs[i][bus_addr[i][1:0]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (periph_clr) begin
        cs_cnt[i]   <= 0;
        resp_cnt[i] <= 0;
        dbl_cs[i]   <= 0;
        prev_cs[i]  <= 1'b1;
      end else begin
        if (cs_[i] === 1'b0) cs_cnt[i] <= cs_cnt[i] + 1;
        if (cs_[i] === 1'b0 && prev_cs[i] === 1'b0) dbl_cs[i] <= dbl_cs[i] + 1;
        if (resp_valid[i] === 1'b1) resp_cnt[i] <= resp_cnt[i] + 1;
        prev_cs[i] <= cs_[i];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem  [NI][4];
  logic [DW-1:0] exp_rdata[NI];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit resp_due(input int k, input int w, input logic rw);
`ifdef PBM_POSTED_WRITE_EN
    return (rw == 1'b0) ? (k == 1) : (k == 3 + w);
`else
    return (k == 3 + w);
`endif
  endfunction

  // One transaction, checked every cycle from accept until the master is back in IDLE.
  task automatic txn(input int i, input logic rw, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit hold);
    int w;
    bit got;
    logic [DW-1:0] exp_rd;
    w   = wc(i);
    got = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (req_ready[i] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("u%0d ready_wait", i), 32'(got), 32'd1);
    if (!got) return;
    if (rw == 1'b0)
      exp_rd = exp_rdata[i];
    else if (a[1:0] == 2'd0)
      exp_rd = ref_mem[i][1][1] ? timer[i] + DW'(2 + w) : timer[i];
    else
      exp_rd = ref_mem[i][a[1:0]];
    req_valid[i] = 1'b1;
    req_rw_[i]   = rw;
    req_addr[i]  = a;
    req_wdata[i] = d;
    for (int k = 1; k <= 4 + w; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid[i] = 1'b0;
      chk($sformatf("u%0d k%0d cs_", i, k), 32'(cs_[i]), (k == 2) ? 32'd0 : 32'd1);
      chk($sformatf("u%0d k%0d resp_valid", i, k), 32'(resp_valid[i]),
          32'(resp_due(k, w, rw)));
      chk($sformatf("u%0d k%0d req_ready", i, k), 32'(req_ready[i]),
          (k == 4 + w) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d k%0d busy", i, k), 32'(busy[i]), (k == 4 + w) ? 32'd0 : 32'd1);
      if (k == 2) begin
        chk($sformatf("u%0d strobe rw_", i), 32'(rw_[i]), 32'(rw));
        chk($sformatf("u%0d strobe addr", i), 32'(bus_addr[i]), 32'(a));
        chk($sformatf("u%0d strobe wdata", i), 32'(bus_wdata[i]), 32'(d));
      end
      if (k == 3 + w) chk($sformatf("u%0d resp_rdata", i), 32'(resp_rdata[i]), 32'(exp_rd));
    end
    exp_rdata[i] = exp_rd;
    if (rw == 1'b0) ref_mem[i][a[1:0]] = d;
  endtask

  initial begin
    int c0, cyc0, r0, s_cs, s_resp, s_wr;
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    periph_clr = 1'b1;
    for (int i = 0; i < NI; i++) begin
      rst_a[i]     = 1'b0;
      req_valid[i] = 1'b0;
      req_rw_[i]   = 1'b1;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      exp_rdata[i] = '0;
      for (int j = 0; j < 4; j++) ref_mem[i][j] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d rst cs_", i), 32'(cs_[i]), 32'd1);
      chk($sformatf("u%0d rst rw_", i), 32'(rw_[i]), 32'd1);
      chk($sformatf("u%0d rst bus_addr", i), 32'(bus_addr[i]), 32'd0);
      chk($sformatf("u%0d rst bus_wdata", i), 32'(bus_wdata[i]), 32'd0);
      chk($sformatf("u%0d rst resp_valid", i), 32'(resp_valid[i]), 32'd0);
      chk($sformatf("u%0d rst resp_rdata", i), 32'(resp_rdata[i]), 32'd0);
      chk($sformatf("u%0d rst req_ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("u%0d rst busy", i), 32'(busy[i]), 32'd0);
      rst_a[i] = 1'b1;
    end
    periph_clr = 1'b0;
    @(negedge clk);

    // Start the counter, let it run, then read it.
    txn(1, 1'b0, 8'd1, 16'h0002, 1'b0);
    chk("u1 timer enable", 32'(regs[1][1][1]), 32'd1);
    repeat (10) @(negedge clk);
    c0   = int'(timer[1]);
    cyc0 = cyc;
    txn(1, 1'b1, 8'd0, 16'h0000, 1'b0);
    chk("u1 timer undisturbed", 32'(timer[1]), 32'(c0 + (cyc - cyc0)));

    // Random traffic on every instance.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 8; n++) begin
        rw = 1'($urandom_range(0, 1));
        a  = AW'($urandom_range(2, 3));
        d  = DW'($urandom);
        txn(i, rw, a, d, 1'b0);
      end
    end

    // Back-to-back with req_valid held high through busy cycles.
    s_cs   = cs_cnt[1];
    s_resp = resp_cnt[1];
    s_wr   = wr_cnt[1];
    txn(1, 1'b0, 8'd2, 16'h1357, 1'b1);
    txn(1, 1'b0, 8'd3, 16'h2468, 1'b1);
    txn(1, 1'b1, 8'd2, 16'h0000, 1'b0);
    chk("b2b cs pulses", 32'(cs_cnt[1] - s_cs), 32'd3);
    chk("b2b resp pulses", 32'(resp_cnt[1] - s_resp), 32'd3);
    chk("b2b writes", 32'(wr_cnt[1] - s_wr), 32'd2);
    chk("b2b reg3", 32'(regs[1][3]), 32'h2468);

    // Reset in the middle of a read's HOLD phase.
    txn(2, 1'b0, 8'd3, 16'hBEEF, 1'b0);
    txn(2, 1'b1, 8'd3, 16'h0000, 1'b0);
    req_valid[2] = 1'b1;
    req_rw_[2]   = 1'b1;
    req_addr[2]  = 8'd2;
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    r0 = resp_cnt[2];
    #2 rst_a[2] = 1'b0;
    #1;
    chk("midrst cs_", 32'(cs_[2]), 32'd1);
    chk("midrst resp_valid", 32'(resp_valid[2]), 32'd0);
    chk("midrst req_ready", 32'(req_ready[2]), 32'd1);
    chk("midrst resp_rdata", 32'(resp_rdata[2]), 32'd0);
    @(negedge clk);
    rst_a[2] = 1'b1;
    exp_rdata[2] = '0;
    repeat (25) @(negedge clk);
    chk("midrst no resp", 32'(resp_cnt[2]), 32'(r0));
    chk("midrst rdata after", 32'(resp_rdata[2]), 32'd0);
    txn(2, 1'b1, 8'd3, 16'h0000, 1'b0);

    // Stop-style command write (posted when the feature is built in).
    txn(1, 1'b0, 8'd1, 16'h0004, 1'b0);

    for (int i = 0; i < NI; i++)
      chk($sformatf("u%0d cs_ double low", i), 32'(dbl_cs[i]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
